// File: rtl/tick_gen_multi_if.sv
// Bundle of the per-channel control and tick signals of tick_gen_multi.
// Each vector carries one lane per channel; div and tick_phase are packed
// with channel i at [i*WIDTH +: WIDTH] and [i*PW +: PW] respectively.
//
// Handshake: there is no valid/ready pair. tick is a one-cycle strobe that
// qualifies tick_phase and wrap in the same cycle. The consumer must take the
// tick in that cycle because it cannot stall the channel.
interface tick_gen_multi_if #(
   parameter int WIDTH  = 32,
   parameter int NCH    = 2,
   parameter int PHASES = 4
);
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

   logic [NCH-1:0]       en;
   logic [NCH-1:0]       mode;
   logic [NCH-1:0]       start;
   logic [NCH*WIDTH-1:0] div;
   logic [NCH-1:0]       tick;
   logic [NCH*PW-1:0]    tick_phase;
   logic [NCH-1:0]       wrap;
   logic [NCH-1:0]       busy;
   // Debug view of the per-channel FSM: 1 = RUN, 0 = IDLE.
   logic [NCH-1:0]       state_dbg;

   modport master (
      output en, mode, start, div,
      input  tick, tick_phase, wrap, busy, state_dbg
   );

   modport slave (
      input  en, mode, start, div,
      output tick, tick_phase, wrap, busy, state_dbg
   );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator. Each channel divides clk by div+1 and emits a
// one-cycle tick. Every tick carries a rolling phase index (0..PHASES-1), and
// the last phase is flagged with wrap. A channel runs either continuously
// until en drops, or one-shot for exactly PHASES ticks. Channels share nothing
// except clk and rst.
module tick_gen_multi #(
   parameter int WIDTH  = 32,
   parameter int NCH    = 2,
   parameter int PHASES = 4
) (
   input  logic               clk,
   input  logic               rst,
   tick_gen_multi_if.slave    bus
);
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Registered per-channel state
   state_t           state_q      [NCH];
   state_t           state_d      [NCH];
   logic [WIDTH-1:0] cnt_q        [NCH];
   logic [WIDTH-1:0] cnt_d        [NCH];
   logic [WIDTH-1:0] div_l_q      [NCH];
   logic [WIDTH-1:0] div_l_d      [NCH];
   logic [PW-1:0]    ph_cnt_q     [NCH];
   logic [PW-1:0]    ph_cnt_d     [NCH];
   logic [PW-1:0]    tick_phase_q [NCH];
   logic [PW-1:0]    tick_phase_d [NCH];
   logic [NCH-1:0]   mode_l_q;
   logic [NCH-1:0]   mode_l_d;
   logic [NCH-1:0]   tick_q;
   logic [NCH-1:0]   tick_d;
   logic [NCH-1:0]   wrap_q;
   logic [NCH-1:0]   wrap_d;

   // Per-channel views of the packed inputs
   logic [WIDTH-1:0] div_ch  [NCH];
   logic [NCH-1:0]   ph_last;
   logic [NCH-1:0]   period_end;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign div_ch[g]     = bus.div[g*WIDTH +: WIDTH];
      // The phase counter sits on the last phase, so the next tick wraps
      assign ph_last[g]    = (ph_cnt_q[g] == PH_LAST);
      // The counter stops at the latched divisor, so div = all ones never overflows
      assign period_end[g] = (cnt_q[g] == div_l_q[g]);

      assign bus.tick_phase[g*PW +: PW] = tick_phase_q[g];
      assign bus.busy[g]                = (state_q[g] == ST_RUN);
      assign bus.state_dbg[g]           = (state_q[g] == ST_RUN);
   end

   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;

   // Next-state logic for every channel: start, count, tick, abort and one-shot end
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i]      = state_q[i];
         cnt_d[i]        = cnt_q[i];
         div_l_d[i]      = div_l_q[i];
         ph_cnt_d[i]     = ph_cnt_q[i];
         tick_phase_d[i] = tick_phase_q[i];
         mode_l_d[i]     = mode_l_q[i];
         tick_d[i]       = 1'b0;
         wrap_d[i]       = 1'b0;

         case (state_q[i])
            ST_IDLE: begin
               // Continuous mode starts as soon as it is enabled. One-shot mode also needs start.
               if (bus.en[i] && (!bus.mode[i] || bus.start[i])) begin
                  state_d[i]  = ST_RUN;
                  cnt_d[i]    = '0;
                  ph_cnt_d[i] = '0;
                  div_l_d[i]  = div_ch[i];
                  mode_l_d[i] = bus.mode[i];
               end
            end

            ST_RUN: begin
               if (!bus.en[i]) begin
                  // Abort: no tick on this edge; phase restarts at 0 on re-entry
                  state_d[i]  = ST_IDLE;
                  cnt_d[i]    = '0;
                  ph_cnt_d[i] = '0;
               end else if (period_end[i]) begin
                  // End of period: emit the tick and pick up any new divisor
                  cnt_d[i]        = '0;
                  div_l_d[i]      = div_ch[i];
                  tick_d[i]       = 1'b1;
                  tick_phase_d[i] = ph_cnt_q[i];
                  wrap_d[i]       = ph_last[i];
                  ph_cnt_d[i]     = ph_last[i] ? '0 : ph_cnt_q[i] + PW'(1);
                  // A one-shot run ends on the same edge that issues its wrap tick
                  if (mode_l_q[i] && ph_last[i]) begin
                     state_d[i] = ST_IDLE;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + WIDTH'(1);
               end
            end

            default: begin
               state_d[i] = ST_IDLE;
            end
         endcase
      end
   end

   // Register all channel state and outputs; rst wins on any edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i]      <= ST_IDLE;
            cnt_q[i]        <= '0;
            div_l_q[i]      <= '0;
            ph_cnt_q[i]     <= '0;
            tick_phase_q[i] <= '0;
         end
         mode_l_q <= '0;
         tick_q   <= '0;
         wrap_q   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i]      <= state_d[i];
            cnt_q[i]        <= cnt_d[i];
            div_l_q[i]      <= div_l_d[i];
            ph_cnt_q[i]     <= ph_cnt_d[i];
            tick_phase_q[i] <= tick_phase_d[i];
         end
         mode_l_q <= mode_l_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
      end
   end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi (NCH=2, PHASES=4).
// Cycle n of a scenario is the clock period that follows edge En, and E0 is the
// first edge after the inputs change. Expected ticks go into per-channel queues.
// Expected busy, reset and drain checks go into a time-ordered check queue.
// A single negedge monitor pops both kinds of entry and compares them.
module tb_tick_gen_multi;
   localparam int WIDTH  = 32;
   localparam int NCH    = 2;
   localparam int PHASES = 4;
   localparam int PW     = 2;
   localparam int EW     = 32 + PW + 1;

   localparam logic [1:0] K_BUSY  = 2'd0;
   localparam logic [1:0] K_ZERO  = 2'd1;
   localparam logic [1:0] K_DRAIN = 2'd2;

   typedef struct packed {
      logic [31:0] at;
      logic [1:0]  kind;
      logic        ch;
      logic        val;
   } chk_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   chk_t          chk_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   tick_gen_multi_if #(.WIDTH(WIDTH), .NCH(NCH), .PHASES(PHASES)) bus ();

   tick_gen_multi #(.WIDTH(WIDTH), .NCH(NCH), .PHASES(PHASES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor and scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] act_e;
      logic [EW-1:0] exp_e;
      logic          have;
      chk_t          c_e;
      for (int c = 0; c < NCH; c++) begin
         if (bus.tick[c]) begin
            act_e = {32'(cyc), bus.tick_phase[c*PW +: PW], bus.wrap[c]};
            have  = 1'b0;
            exp_e = '0;
            if (c == 0) begin
               if (exp_q0.size() > 0) begin have = 1'b1; exp_e = exp_q0.pop_front(); end
            end else begin
               if (exp_q1.size() > 0) begin have = 1'b1; exp_e = exp_q1.pop_front(); end
            end
            n_checks++;
            if (!have) begin
               n_fail++;
               $display("FAIL tick ch%0d: unexpected tick at cyc %0d phase %0d wrap %0b, none expected",
                        c, cyc, act_e[PW:1], act_e[0]);
            end else if (act_e !== exp_e) begin
               n_fail++;
               $display("FAIL tick ch%0d: got cyc %0d phase %0d wrap %0b, want cyc %0d phase %0d wrap %0b",
                        c, act_e[EW-1:PW+1], act_e[PW:1], act_e[0],
                        exp_e[EW-1:PW+1], exp_e[PW:1], exp_e[0]);
            end
         end
      end
      while (chk_q.size() > 0 && chk_q[0].at <= 32'(cyc)) begin
         c_e = chk_q.pop_front();
         n_checks++;
         case (c_e.kind)
            K_BUSY: begin
               if (bus.busy[c_e.ch] !== c_e.val) begin
                  n_fail++;
                  $display("FAIL busy ch%0d cyc %0d: got %0b want %0b", c_e.ch, cyc, bus.busy[c_e.ch], c_e.val);
               end
            end
            K_ZERO: begin
               if ({bus.tick, bus.wrap, bus.busy, bus.tick_phase} !== '0) begin
                  n_fail++;
                  $display("FAIL reset_state cyc %0d: tick %b wrap %b busy %b phase %b, want all 0",
                           cyc, bus.tick, bus.wrap, bus.busy, bus.tick_phase);
               end
            end
            default: begin
               if (exp_q0.size() + exp_q1.size() != 0) begin
                  n_fail++;
                  $display("FAIL drain cyc %0d: %0d expected ticks never seen, want 0",
                           cyc, exp_q0.size() + exp_q1.size());
               end
            end
         endcase
      end
   end

   // Driver tasks
   task automatic wait_to(input int at);
      while (cyc < at) @(negedge clk);
   endtask

   task automatic exp_tick(input int ch, input int at, input int ph, input bit w);
      logic [EW-1:0] e;
      e = {32'(at), PW'(ph), w};
      if (ch == 0) exp_q0.push_back(e);
      else         exp_q1.push_back(e);
   endtask

   task automatic exp_chk(input logic [1:0] kind, input int at, input int ch, input bit v);
      chk_t e;
      e.at   = 32'(at);
      e.kind = kind;
      e.ch   = 1'(ch);
      e.val  = v;
      chk_q.push_back(e);
   endtask

   task automatic set_ch(input int ch, input bit e, input bit m, input logic [WIDTH-1:0] d);
      bus.en[ch]                 = e;
      bus.mode[ch]               = m;
      bus.div[ch*WIDTH +: WIDTH] = d;
   endtask

   task automatic drain(input int at);
      exp_chk(K_DRAIN, at, 0, 1'b0);
      wait_to(at + 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      bus.en    = '0;
      bus.mode  = '0;
      bus.start = '0;
      bus.div   = '0;
      exp_chk(K_ZERO, cyc + 1, 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Stimulus
   initial begin
      int e0;
      int e1;
      bus.en    = '0;
      bus.mode  = '0;
      bus.start = '0;
      bus.div   = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // 1: ch0 continuous div=3 -> ticks every 4 cycles, wrap on phase 3
      e0 = cyc + 1;
      set_ch(0, 1'b1, 1'b0, 32'd3);
      exp_chk(K_BUSY, e0 + 1, 0, 1'b1);
      for (int k = 0; k < 5; k++) exp_tick(0, e0 + 4*(k+1), k % 4, (k % 4) == 3);
      wait_to(e0 + 20);
      bus.en[0] = 1'b0;
      exp_chk(K_BUSY, e0 + 21, 0, 1'b0);
      drain(e0 + 30);

      // 2: div=0 continuous -> tick every cycle, wrap every 4th
      e0 = cyc + 1;
      set_ch(0, 1'b1, 1'b0, 32'd0);
      for (int n = 1; n <= 12; n++) exp_tick(0, e0 + n, (n-1) % 4, ((n-1) % 4) == 3);
      wait_to(e0 + 12);
      bus.en[0] = 1'b0;
      drain(e0 + 18);

      // 3: ch1 one-shot div=1; starts while busy and on the final edge are ignored
      e0 = cyc + 1;
      set_ch(1, 1'b1, 1'b1, 32'd1);
      bus.start[1] = 1'b1;
      for (int k = 0; k < 4; k++) exp_tick(1, e0 + 2*(k+1), k, k == 3);
      exp_chk(K_BUSY, e0 + 1, 1, 1'b1);
      exp_chk(K_BUSY, e0 + 5, 1, 1'b1);
      exp_chk(K_BUSY, e0 + 7, 1, 1'b1);
      exp_chk(K_BUSY, e0 + 8, 1, 1'b0);
      exp_chk(K_BUSY, e0 + 9, 1, 1'b0);
      @(negedge clk);
      bus.start[1] = 1'b0;
      wait_to(e0 + 5); bus.start[1] = 1'b1;
      wait_to(e0 + 6); bus.start[1] = 1'b0;
      wait_to(e0 + 7); bus.start[1] = 1'b1;
      wait_to(e0 + 8); bus.start[1] = 1'b0;
      wait_to(e0 + 9); bus.start[1] = 1'b1;
      for (int k = 0; k < 4; k++) exp_tick(1, e0 + 12 + 2*k, k, k == 3);
      exp_chk(K_BUSY, e0 + 10, 1, 1'b1);
      exp_chk(K_BUSY, e0 + 17, 1, 1'b1);
      exp_chk(K_BUSY, e0 + 18, 1, 1'b0);
      wait_to(e0 + 10); bus.start[1] = 1'b0;
      wait_to(e0 + 18);
      set_ch(1, 1'b0, 1'b0, 32'd0);
      drain(e0 + 25);

      // 4: div 3 -> 7 mid-period takes effect only after the next tick
      e0 = cyc + 1;
      set_ch(0, 1'b1, 1'b0, 32'd3);
      exp_tick(0, e0 + 4,  0, 1'b0);
      exp_tick(0, e0 + 12, 1, 1'b0);
      exp_tick(0, e0 + 20, 2, 1'b0);
      exp_tick(0, e0 + 28, 3, 1'b1);
      wait_to(e0 + 2);
      bus.div[0 +: WIDTH] = 32'd7;
      wait_to(e0 + 28);
      bus.en[0] = 1'b0;
      drain(e0 + 40);

      // 5: abort with en, re-enable restarts phase at 0, then rst mid-period
      e0 = cyc + 1;
      set_ch(0, 1'b1, 1'b0, 32'd3);
      exp_tick(0, e0 + 4, 0, 1'b0);
      wait_to(e0 + 6);
      bus.en[0] = 1'b0;
      exp_chk(K_BUSY, e0 + 8, 0, 1'b0);
      wait_to(e0 + 10);
      bus.en[0] = 1'b1;
      e1 = e0 + 11;
      exp_tick(0, e1 + 4, 0, 1'b0);
      exp_tick(0, e1 + 8, 1, 1'b0);
      wait_to(e1 + 10);
      rst = 1'b1;
      exp_chk(K_ZERO, e1 + 11, 0, 1'b0);
      wait_to(e1 + 11);
      rst       = 1'b0;
      bus.en[0] = 1'b0;
      exp_chk(K_BUSY, e1 + 13, 0, 1'b0);
      drain(e1 + 20);

      // 6: ch0 div=2 and ch1 div=4 together; mode change in RUN ignored
      e0 = cyc + 1;
      set_ch(0, 1'b1, 1'b0, 32'd2);
      set_ch(1, 1'b1, 1'b0, 32'd4);
      for (int k = 0; k < 5; k++) exp_tick(0, e0 + 3*(k+1), k % 4, (k % 4) == 3);
      for (int k = 0; k < 3; k++) exp_tick(1, e0 + 5*(k+1), k, 1'b0);
      exp_chk(K_BUSY, e0 + 14, 0, 1'b1);
      wait_to(e0 + 1);
      bus.mode[0] = 1'b1;
      wait_to(e0 + 15);
      bus.en = '0;
      drain(e0 + 25);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
